// File: rtl/conv_pkg.sv
// ============================================================================
//  Module   : conv_pkg
//  Purpose  : Shared types and helpers for the conv engine result collector.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package conv_pkg;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } collector_state_t;

    // Per-element ReLU keep bit: a set sign bit forces the element to zero.
    function automatic logic relu_keep(input logic sign_bit);
        return ~sign_bit;
    endfunction

endpackage

`default_nettype wire

// File: rtl/conv_result_column_ram.sv
// ============================================================================
//  Module   : conv_result_column_ram
//  Purpose  : One (channel,column) result store: sync write, async read.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_result_column_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 6,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/conv_result_collector.sv
// ============================================================================
//  Module   : conv_result_collector
//  Purpose  : Captures conv engine result rows, then drains the full feature
//             map as a val/rdy stream, one channel row per beat.
//             Build option: CONV_RESULT_RELU_EN applies ReLU to drained data.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_result_collector
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH          = 8,
    parameter int RESULT_W            = 6,
    parameter int RESULT_H            = 6,
    parameter int RESULT_D            = 4,
    parameter int RESULT_H_ADDR_WIDTH = $clog2(RESULT_H)
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [RESULT_D*RESULT_W*RESULT_H_ADDR_WIDTH-1:0] wr_address,
    input  logic [RESULT_D*RESULT_W*DATA_WIDTH-1:0]       wr_data,
    input  logic [RESULT_D*RESULT_W-1:0]                  wr_en,
    output logic                                          collect_rdy,
    output logic                                          out_val,
    input  logic                                          out_rdy,
    output logic [RESULT_W*DATA_WIDTH-1:0]                out_data,
    output logic [$clog2(RESULT_D)-1:0]                   out_d,
    output logic [RESULT_H_ADDR_WIDTH-1:0]                out_h,
    output logic                                          out_last,
    output logic                                          done,
    output logic                                          err
);

    localparam int AW       = RESULT_H_ADDR_WIDTH;
    localparam int c_d_w    = $clog2(RESULT_D);
    localparam int c_n_cols = RESULT_D * RESULT_W;
    localparam int c_last   = c_n_cols - 1;

    localparam logic [0:0] c_st_collect = COLLECT;
    localparam logic [0:0] c_st_drain   = DRAIN;

    logic [0:0]            r_state;
    logic [c_d_w-1:0]      r_d_cnt;
    logic [AW-1:0]         r_h_cnt;
    logic                  r_done;
    logic                  r_err;

    logic [c_n_cols-1:0]   w_col_ok;
    logic [c_n_cols-1:0]   w_col_we;
    logic [DATA_WIDTH-1:0] w_rd_data [RESULT_D][RESULT_W];
    logic                  w_collecting;
    logic                  w_trigger;
    logic                  w_handshake;
    logic                  w_last;
    logic                  w_err_set;

    assign w_collecting = (r_state == c_st_collect);

    generate
        for (genvar gd = 0; gd < RESULT_D; gd++) begin : g_d
            for (genvar gw = 0; gw < RESULT_W; gw++) begin : g_w
                localparam int c_i = gd * RESULT_W + gw;
                logic [AW-1:0] w_addr;

                assign w_addr        = wr_address[c_i*AW +: AW];
                // Widened compare stays correct when RESULT_H is a power of two.
                assign w_col_ok[c_i] = ({1'b0, w_addr} < (AW+1)'(RESULT_H));
                assign w_col_we[c_i] = w_collecting && wr_en[c_i] && w_col_ok[c_i];

                conv_result_column_ram #(
                    .DATA_WIDTH (DATA_WIDTH),
                    .DEPTH      (RESULT_H),
                    .ADDR_WIDTH (AW)
                ) u_ram (
                    .clk   (clk),
                    .we    (w_col_we[c_i]),
                    .waddr (w_addr),
                    .wdata (wr_data[c_i*DATA_WIDTH +: DATA_WIDTH]),
                    .raddr (r_h_cnt),
                    .rdata (w_rd_data[gd][gw])
                );
            end
        end
    endgenerate

    // Only the final column landing on the final row starts the drain.
    assign w_trigger = w_collecting && wr_en[c_last] &&
                       (wr_address[c_last*AW +: AW] == AW'(RESULT_H - 1));

    assign w_handshake = !w_collecting && out_rdy;
    assign w_last      = !w_collecting &&
                         (r_d_cnt == c_d_w'(RESULT_D - 1)) &&
                         (r_h_cnt == AW'(RESULT_H - 1));

    always_comb begin
        w_err_set = 1'b0;
        if (w_collecting) begin
            w_err_set = (|(wr_en & ~w_col_ok)) ||
                        ((wr_en != '0) && (wr_en != '1));
        end else begin
            w_err_set = |wr_en;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_collect;
            r_d_cnt <= '0;
            r_h_cnt <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            case (r_state)
                c_st_collect: begin
                    if (w_trigger) begin
                        r_state <= c_st_drain;
                        r_d_cnt <= '0;
                        r_h_cnt <= '0;
                    end
                end
                c_st_drain: begin
                    if (w_handshake) begin
                        if (w_last) begin
                            r_state <= c_st_collect;
                            r_d_cnt <= '0;
                            r_h_cnt <= '0;
                            r_done  <= 1'b1;
                        end else if (r_h_cnt == AW'(RESULT_H - 1)) begin
                            r_h_cnt <= '0;
                            r_d_cnt <= r_d_cnt + c_d_w'(1);
                        end else begin
                            r_h_cnt <= r_h_cnt + AW'(1);
                        end
                    end
                end
                default: r_state <= c_st_collect;
            endcase
        end
    end

    generate
        for (genvar gw = 0; gw < RESULT_W; gw++) begin : g_out
            logic [DATA_WIDTH-1:0] w_elem;
            assign w_elem = w_rd_data[r_d_cnt][gw];
`ifdef CONV_RESULT_RELU_EN
            assign out_data[gw*DATA_WIDTH +: DATA_WIDTH] =
                {DATA_WIDTH{relu_keep(w_elem[DATA_WIDTH-1])}} & w_elem;
`else
            assign out_data[gw*DATA_WIDTH +: DATA_WIDTH] = w_elem;
`endif
        end
    endgenerate

    assign collect_rdy = w_collecting;
    assign out_val     = !w_collecting;
    assign out_d       = r_d_cnt;
    assign out_h       = r_h_cnt;
    assign out_last    = w_last;
    assign done        = r_done;
    assign err         = r_err;

endmodule

`default_nettype wire

// File: tb/tb_conv_result_collector.sv
// ============================================================================
//  Module   : tb_conv_result_collector
//  Purpose  : Directed/randomized self-checking bench for conv_result_collector.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv_result_collector;

    localparam int D  = 4;
    localparam int W  = 6;
    localparam int H  = 6;
    localparam int DW = 8;
    localparam int AW = 3;
    localparam int N  = D * W;
    localparam int NB = D * H;

    logic              clk = 1'b0;
    logic              reset;
    logic [N*AW-1:0]   wr_address;
    logic [N*DW-1:0]   wr_data;
    logic [N-1:0]      wr_en;
    logic              collect_rdy;
    logic              out_val;
    logic              out_rdy;
    logic [W*DW-1:0]   out_data;
    logic [1:0]        out_d;
    logic [AW-1:0]     out_h;
    logic              out_last;
    logic              done;
    logic              err;

    int total = 0;
    int bad   = 0;

    // Reference image of what the buffer should hold: [channel][column][row].
    logic [DW-1:0] mem_m [D][W][H];

    conv_result_collector #(
        .DATA_WIDTH (DW),
        .RESULT_W   (W),
        .RESULT_H   (H),
        .RESULT_D   (D)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_address  (wr_address),
        .wr_data     (wr_data),
        .wr_en       (wr_en),
        .collect_rdy (collect_rdy),
        .out_val     (out_val),
        .out_rdy     (out_rdy),
        .out_data    (out_data),
        .out_d       (out_d),
        .out_h       (out_h),
        .out_last    (out_last),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] relu_ref(input logic [DW-1:0] v);
`ifdef CONV_RESULT_RELU_EN
        return ($signed(v) < 0) ? '0 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [W*DW-1:0] exp_row(input int d, input int h);
        logic [W*DW-1:0] r;
        for (int w = 0; w < W; w++) r[w*DW +: DW] = relu_ref(mem_m[d][w][h]);
        return r;
    endfunction

    // mode 0: {d,w,h} pattern, 1: random, 2: random with 8'hF0/8'h7F in columns 0/1
    task automatic write_row(input int h, input int mode, input int bad_col, input logic [N-1:0] en);
        for (int d = 0; d < D; d++) begin
            for (int w = 0; w < W; w++) begin
                int            i;
                logic [DW-1:0] v;
                logic [AW-1:0] a;
                i = d * W + w;
                case (mode)
                    0:       v = 8'((d << 6) | (w << 3) | h);
                    2:       v = (w == 0) ? 8'hF0 : (w == 1) ? 8'h7F : 8'($urandom);
                    default: v = 8'($urandom);
                endcase
                a = (i == bad_col) ? 3'd7 : 3'(h);
                wr_address[i*AW +: AW] = a;
                wr_data[i*DW +: DW]    = v;
                if (en[i] && int'(a) < H) mem_m[d][w][a] = v;
            end
        end
        wr_en = en;
        tick;
        wr_en = '0;
    endtask

    task automatic drain(input bit toggle, input int inject_at, input int abort_at, input bit check_len);
        int k   = 0;
        int cyc = 0;
        bit rdy;
        bit injected = 0;
        while (k < NB && cyc < 400) begin
            if (out_val !== 1'b1) begin
                chk("out_val_in_drain", 64'(out_val), 64'd1);
                break;
            end
            chk("beat_d", 64'(out_d), 64'(k / H));
            chk("beat_h", 64'(out_h), 64'(k % H));
            chk("beat_last", 64'(out_last), 64'(k == NB - 1));
            chk("beat_data", 64'(out_data), 64'(exp_row(k / H, k % H)));
            chk("collect_rdy_drain", 64'(collect_rdy), 64'd0);
            if (k == abort_at) begin
                out_rdy = 1'b0;
                reset   = 1'b1;
                tick;
                reset = 1'b0;
                chk("abort_out_val", 64'(out_val), 64'd0);
                chk("abort_collect_rdy", 64'(collect_rdy), 64'd1);
                chk("abort_done", 64'(done), 64'd0);
                return;
            end
            rdy     = toggle ? (cyc % 2 == 0) : 1'b1;
            out_rdy = rdy;
            if (k == inject_at && !injected) begin
                injected = 1;
                for (int d = 0; d < D; d++)
                    for (int w = 0; w < W; w++) begin
                        wr_address[(d*W+w)*AW +: AW] = 3'(H - 1);
                        wr_data[(d*W+w)*DW +: DW]    = ~mem_m[d][w][H-1];
                    end
                wr_en = '1;
            end
            tick;
            wr_en = '0;
            if (rdy) k++;
            cyc++;
        end
        out_rdy = 1'b0;
        if (check_len) chk("drain_cycles", 64'(cyc), 64'(NB));
        chk("done_pulse", 64'(done), 64'd1);
        chk("post_out_val", 64'(out_val), 64'd0);
        chk("post_collect_rdy", 64'(collect_rdy), 64'd1);
        tick;
        chk("done_clears", 64'(done), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        wr_en      = '0;
        wr_address = '0;
        wr_data    = '0;
        out_rdy    = 1'b0;
        tick;
        tick;
        chk("rst_collect_rdy", 64'(collect_rdy), 64'd1);
        chk("rst_out_val", 64'(out_val), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        reset = 1'b0;
        tick;

        // In-order frame with the {d,w,h} pattern.
        for (int h = 0; h < H; h++) begin
            write_row(h, 0, -1, '1);
            if (h < H - 1) chk("no_early_drain", 64'(out_val), 64'd0);
        end
        drain(0, -1, -1, 1);
        chk("err_clean_frame", 64'(err), 64'd0);

        // Final row first: drain starts immediately with stale rows 0..4.
        write_row(H - 1, 1, -1, '1);
        drain(0, -1, -1, 1);
        for (int h = 0; h < H - 1; h++) begin
            write_row(h, 1, -1, '1);
            chk("no_trigger_low_rows", 64'(out_val), 64'd0);
        end

        // Backpressure: stall every other cycle.
        write_row(H - 1, 1, -1, '1);
        drain(1, -1, -1, 0);
        chk("err_after_stall", 64'(err), 64'd0);

        // Out-of-range address on (2,3), then a write attempt mid-drain.
        for (int h = 0; h < H - 1; h++) write_row(h, 1, (h == 2) ? (2 * W + 3) : -1, '1);
        chk("err_bad_addr", 64'(err), 64'd1);
        chk("bad_addr_no_drain", 64'(out_val), 64'd0);
        write_row(H - 1, 1, -1, '1);
        drain(0, 3, -1, 1);
        chk("err_sticky", 64'(err), 64'd1);

        // Reset clears err; partial strobes write their columns and flag err.
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("err_reset", 64'(err), 64'd0);
        write_row(2, 1, -1, 24'h00003F);
        chk("err_partial_en", 64'(err), 64'd1);
        for (int h = 0; h < H; h++) write_row(h, 1, -1, '1);
        drain(0, -1, 5, 0);
        chk("err_after_abort", 64'(err), 64'd0);
        for (int h = 0; h < H; h++) write_row(h, 1, -1, '1);
        drain(0, -1, -1, 1);

        // Sign handling on 8'hF0 / 8'h7F.
        for (int h = 0; h < H; h++) write_row(h, 2, -1, '1);
        drain(0, -1, -1, 1);
        chk("err_final", 64'(err), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
